// File: rtl/key_board_pkg.sv
// Shared definitions for the keypad front end: key-code width and defaults
// (common with the matrix scanner) and the entry controller state encoding.
package key_board_pkg;

  // Scanner key code width; codes 0..15.
  localparam int unsigned KEY_W = 4;

  // Default command key codes.
  localparam logic [KEY_W-1:0] DEF_KEY_BKSP  = 4'd13;
  localparam logic [KEY_W-1:0] DEF_KEY_CLEAR = 4'd14;
  localparam logic [KEY_W-1:0] DEF_KEY_ENTER = 4'd15;

  // Entry controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Codes 0..9 are decimal digits.
  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_entry_timer.sv
// Inactivity counter for the entry controller. Counts while en_i is high,
// returns to zero on clr_i or on expiry, and flags expire_o on the cycle the
// count reaches TIMEOUT_CYC-1.
module key_entry_timer #(
  parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  // Next count: clearing has priority, expiry restarts from zero, so the
  // counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: collects up to DIGITS decimal keys into a packed
// BCD value (newest digit in [3:0]), supports backspace/clear/enter, and
// holds the finished entry on a valid/ready handshake.
// Build option: define KEY_ENTRY_TIMEOUT_EN to enable the inactivity
// auto-abort in ENTRY; otherwise the timer is absent and timeout stays 0.
module key_entry_ctrl
  import key_board_pkg::*;
#(
  parameter int unsigned      DIGITS      = 4,
  parameter int unsigned      TIMEOUT_CYC = 250_000_000,
  parameter logic [KEY_W-1:0] KEY_BKSP    = DEF_KEY_BKSP,
  parameter logic [KEY_W-1:0] KEY_CLEAR   = DEF_KEY_CLEAR,
  parameter logic [KEY_W-1:0] KEY_ENTER   = DEF_KEY_ENTER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_flag,
  input  logic [KEY_W-1:0]      key_value,
  input  logic                  entry_ready,
  output logic                  entry_valid,
  output logic [4*DIGITS-1:0]   entry_value,
  output logic [3:0]            entry_len,
  output logic                  busy,
  output logic                  err_ovf,
  output logic                  key_drop,
  output logic                  timeout
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam logic [3:0]  LEN_MAX = 4'(DIGITS);

  // Reject unsupported configurations at elaboration.
  if (DIGITS < 1 || DIGITS > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("key_entry_ctrl: DIGITS must be 1..8 and TIMEOUT_CYC at least 2");
  end

  state_e             state_q;
  logic [VAL_W-1:0]   value_q;
  logic [3:0]         len_q;
  logic               valid_q;
  logic               busy_q;
  logic               ovf_q;
  logic               drop_q;
  logic               timeout_q;
  logic               expire;

  logic key_digit;
  logic key_cmd;

  assign key_digit = is_digit(key_value);
  assign key_cmd   = (key_value == KEY_BKSP) || (key_value == KEY_CLEAR) ||
                     (key_value == KEY_ENTER);

`ifdef KEY_ENTRY_TIMEOUT_EN
  logic tmr_en;
  logic tmr_clr;

  // The timer runs only in ENTRY and restarts on any key seen there.
  assign tmr_en  = (state_q == ST_ENTRY);
  assign tmr_clr = key_flag || (state_q != ST_ENTRY);

  key_entry_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Entry FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      value_q   <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (key_flag && key_digit) begin
            value_q <= VAL_W'(key_value);
            len_q   <= 4'd1;
            busy_q  <= 1'b1;
            state_q <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          // A key arriving on the expiry cycle takes priority over abort.
          if (key_flag) begin
            if (key_digit) begin
              if (len_q < LEN_MAX) begin
                value_q <= (value_q << 4) | VAL_W'(key_value);
                len_q   <= len_q + 4'd1;
              end else begin
                ovf_q   <= 1'b1;
              end
            end else if (key_value == KEY_BKSP) begin
              value_q <= value_q >> 4;
              len_q   <= len_q - 4'd1;
              if (len_q == 4'd1) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else if (key_value == KEY_CLEAR) begin
              value_q <= '0;
              len_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if (key_value == KEY_ENTER) begin
              valid_q <= 1'b1;
              state_q <= ST_HOLD;
            end
          end else if (expire) begin
            value_q   <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Keys cannot edit a held entry, including on the handshake cycle.
          if (key_flag && (key_digit || key_cmd)) begin
            drop_q <= 1'b1;
          end
          if (valid_q && entry_ready) begin
            valid_q <= 1'b0;
            value_q <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign entry_valid = valid_q;
  assign entry_value = value_q;
  assign entry_len   = len_q;
  assign busy        = busy_q;
  assign err_ovf     = ovf_q;
  assign key_drop    = drop_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: directed scenarios plus random key
// traffic, compared every cycle against a digit-list reference model.
module tb_key_entry_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned TO_CYC = 100;
  localparam logic [3:0] K_BKSP  = 4'd13;
  localparam logic [3:0] K_CLEAR = 4'd14;
  localparam logic [3:0] K_ENTER = 4'd15;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                key_flag = 1'b0;
  logic [3:0]          key_value = 4'd0;
  logic                entry_ready = 1'b0;
  logic                entry_valid;
  logic [4*DIGITS-1:0] entry_value;
  logic [3:0]          entry_len;
  logic                busy;
  logic                err_ovf;
  logic                key_drop;
  logic                timeout;

  key_entry_ctrl #(
    .DIGITS      (DIGITS),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .entry_ready (entry_ready),
    .entry_valid (entry_valid),
    .entry_value (entry_value),
    .entry_len   (entry_len),
    .busy        (busy),
    .err_ovf     (err_ovf),
    .key_drop    (key_drop),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the digits typed so far (oldest first), whether the
  // entry is being offered to the consumer, and cycles without a key.
  int unsigned m_digits[$];
  bit          m_holding;
  int unsigned m_quiet;
  bit          m_ovf, m_drop, m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_value();
    logic [31:0] v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic m_clear();
    m_digits.delete();
    m_holding = 0;
    m_quiet   = 0;
    m_ovf = 0; m_drop = 0; m_to = 0;
  endtask

  // Apply one clock edge of stimulus to the model.
  task automatic m_step(input bit f, input logic [3:0] v, input bit r);
    bit dig = (v <= 9);
    bit cmd = (v == K_BKSP) || (v == K_CLEAR) || (v == K_ENTER);
    m_ovf = 0; m_drop = 0; m_to = 0;
    if (m_holding) begin
      m_quiet = 0;
      if (f && (dig || cmd)) m_drop = 1;
      if (r) begin
        m_holding = 0;
        m_digits.delete();
      end
    end else if (m_digits.size() == 0) begin
      m_quiet = 0;
      if (f && dig) m_digits.push_back(v);
    end else if (f) begin
      m_quiet = 0;
      if (dig) begin
        if (m_digits.size() < DIGITS) m_digits.push_back(v);
        else m_ovf = 1;
      end else if (v == K_BKSP) begin
        void'(m_digits.pop_back());
      end else if (v == K_CLEAR) begin
        m_digits.delete();
      end else if (v == K_ENTER) begin
        m_holding = 1;
      end
    end else begin
`ifdef KEY_ENTRY_TIMEOUT_EN
      if (m_quiet == TO_CYC - 1) begin
        m_digits.delete();
        m_to    = 1;
        m_quiet = 0;
      end else begin
        m_quiet++;
      end
`endif
    end
  endtask

  task automatic check_all();
    check("value",   32'(entry_value), m_value());
    check("len",     32'(entry_len),   32'(m_digits.size()));
    check("valid",   32'(entry_valid), 32'(m_holding));
    check("busy",    32'(busy),        32'(m_holding || m_digits.size() != 0));
    check("err_ovf", 32'(err_ovf),     32'(m_ovf));
    check("key_drop",32'(key_drop),    32'(m_drop));
    check("timeout", 32'(timeout),     32'(m_to));
  endtask

  // One clock: drive at the falling edge, compare at the next falling edge.
  task automatic cycle(input bit f, input logic [3:0] v, input bit r);
    key_flag    = f;
    key_value   = v;
    entry_ready = r;
    m_step(f, v, r);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic press(input logic [3:0] v);
    cycle(1'b1, v, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset();
    key_flag = 0; key_value = 0; entry_ready = 0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy",  32'(busy),        32'd0);
    check("async_rst_value", 32'(entry_value), 32'd0);
    check("async_rst_valid", 32'(entry_valid), 32'd0);
    m_clear();
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    m_clear();
    repeat (2) @(negedge clk);
    check("reset_value", 32'(entry_value), 32'd0);
    check("reset_len",   32'(entry_len),   32'd0);
    check_all();
    rst = 1'b1;

    // 1,2,3,ENTER then a stalled consumer, then the handshake.
    press(1); press(2); press(3); press(K_ENTER);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 4'd0, 1'b0);
      check("hold_valid", 32'(entry_valid), 32'd1);
      check("hold_value", 32'(entry_value), 32'h0123);
      check("hold_len",   32'(entry_len),   32'd3);
    end
    cycle(1'b0, 4'd0, 1'b1);
    check("hs_valid", 32'(entry_valid), 32'd0);
    check("hs_busy",  32'(busy),        32'd0);

    // Overflow on the fifth digit.
    press(9); press(8); press(7); press(6); press(5);
    check("ovf_pulse", 32'(err_ovf),     32'd1);
    check("ovf_value", 32'(entry_value), 32'h9876);
    check("ovf_len",   32'(entry_len),   32'd4);
    idle(1);
    press(K_CLEAR);

    // Backspace down to empty.
    press(4); press(5); press(K_BKSP);
    check("bksp1_value", 32'(entry_value), 32'h0004);
    press(K_BKSP);
    check("bksp2_value", 32'(entry_value), 32'h0000);
    check("bksp2_busy",  32'(busy),        32'd0);

    // Unused codes change nothing; CLEAR returns to idle.
    press(7); press(10); press(11); press(12);
    check("ign_value", 32'(entry_value), 32'h0007);
    check("ign_len",   32'(entry_len),   32'd1);
    press(K_CLEAR);
    check("clr_value", 32'(entry_value), 32'h0000);

    // Keys in HOLD are dropped, also on the handshake cycle.
    press(4); press(2); press(K_ENTER);
    press(3);
    check("drop_pulse", 32'(key_drop),    32'd1);
    check("drop_value", 32'(entry_value), 32'h0042);
    cycle(1'b1, 4'd3, 1'b1);
    check("drop_hs", 32'(key_drop), 32'd1);
    cycle(1'b0, 4'd0, 1'b1);   // ready while idle: no effect

    // Reset mid-entry and mid-hold.
    press(1); press(2);
    do_reset();
    press(3); press(K_ENTER);
    do_reset();

`ifdef KEY_ENTRY_TIMEOUT_EN
    press(5);
    idle(TO_CYC - 1);
    check("to_early", 32'(timeout), 32'd0);
    idle(1);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_busy",  32'(busy),    32'd0);
    press(5);
    idle(TO_CYC - 1);
    press(5);
    check("to_keywins_to",    32'(timeout),     32'd0);
    check("to_keywins_value", 32'(entry_value), 32'h0055);
    idle(TO_CYC);
    check("to_pulse2", 32'(timeout), 32'd1);
`else
    press(5);
    idle(TO_CYC + 50);
    check("noto_busy",  32'(busy),    32'd1);
    check("noto_pulse", 32'(timeout), 32'd0);
    press(K_CLEAR);
`endif

    // Random traffic with occasional long silences.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 250) idle(TO_CYC + 5);
      cycle($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
